hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: id_valid  in  1  ID stage holds a real instruction.
REQ-004 SHALL have: id_rs1, id_rs2  in  5 each  ID-stage source registers.
REQ-005 SHALL have: ex_rs1, ex_rs2  in  5 each  EX-stage source registers.
REQ-006 SHALL have: ex_rd, mem_rd, wb_rd  in  5 each  destination registers per stage.
REQ-007 SHALL have: ex_reg_w, mem_reg_w, wb_reg_w  in  1 each  stage writes rd.
REQ-008 SHALL have: ex_mem2reg  in  1  EX instruction is a load.
REQ-009 SHALL have: ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-010 SHALL have: ex_mc_start  in  1  multi-cycle op present in EX; mc_done  in  1  multi-cycle unit result ready.
REQ-011 SHALL have outputs: stall_if, stall_id, stall_ex  1 each  hold PC, IF/ID, ID/EX.
REQ-012 SHALL have: flush_id, bubble_ex, bubble_mem  1 each  zero IF/ID, ID/EX, EX/MEM.
REQ-013 SHALL have: fwd_a, fwd_b  2 each  EX operand source: 00 regfile, 01 MEM, 10 WB.
REQ-014 SHALL have: stall_cnt  16  saturating count of stall_if cycles.

Function
REQ-015 SHALL implement FSM states RUN, MC_BUSY; stall/flush outputs combinational from state and inputs; stall_cnt registered.
REQ-016 RUN, ex_mc_start=1, mc_done=0: assert stall_if, stall_id, stall_ex, bubble_mem; next state MC_BUSY.
REQ-017 RUN, ex_mc_start=1, mc_done=1: zero-wait op, no stall, remain RUN.
REQ-018 MC_BUSY, mc_done=0: same outputs as REQ-016, remain MC_BUSY; ex_redirect ignored.
REQ-019 MC_BUSY, mc_done=1: no stall that cycle; next state RUN.
REQ-020 Load-use in RUN: id_valid & ex_mem2reg & ex_reg_w & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) -> stall_if, stall_id, bubble_ex for exactly that cycle.
REQ-021 RUN, ex_redirect=1: flush_id=1, bubble_ex=1, all stalls 0; overrides REQ-020.
REQ-022 Priority: rst > multi-cycle hold > ex_redirect > RAW/load-use stall.
REQ-023 x0 (rd=0) SHALL never cause a stall or a forward.
REQ-024 WB-vs-ID hazards SHALL need no action; register file is write-through.
REQ-025 stall_cnt SHALL increment each cycle stall_if=1 and hold at 16'hFFFF.
REQ-026 All outputs other than stall_cnt SHALL depend only on current inputs and state (no added latency).

Reset
REQ-027 While rst=1, all stall/flush/bubble outputs SHALL be 0 and fwd_a = fwd_b = 00.
REQ-028 On the clock edge with rst=1, state SHALL become RUN and stall_cnt 0, including mid MC_BUSY.

Configuration
REQ-029 Macro HAZARD_FWD_EN SHALL select forwarding.
REQ-030 Defined: fwd_a SHALL be 01 if mem_reg_w & mem_rd!=0 & mem_rd==ex_rs1, else 10 if wb_reg_w & wb_rd!=0 & wb_rd==ex_rs1, else 00; MEM has priority over WB; fwd_b likewise on ex_rs2. Stalls SHALL arise only from REQ-020.
REQ-031 Undefined: fwd_a = fwd_b = 00 constantly. A RAW stall (stall_if, stall_id, bubble_ex) SHALL be asserted whenever id_valid and either id_rs matches a nonzero ex_rd with ex_reg_w, or a nonzero mem_rd with mem_reg_w.

Verification
REQ-032 Load x5 in EX (ex_mem2reg=1, ex_reg_w=1, ex_rd=5), ID id_rs1=5 -> stall_if=stall_id=bubble_ex=1 for one cycle, stall_cnt 0->1.
REQ-033 ex_mc_start=1, mc_done after 4 cycles -> stall_if/stall_ex high 4 cycles, low on the mc_done cycle, state back to RUN, stall_cnt=4.
REQ-034 ex_redirect=1 together with a load-use match -> flush_id=1, bubble_ex=1, stall_if=0.
REQ-035 With HAZARD_FWD_EN: mem_rd=wb_rd=ex_rs1=7, both reg_w=1 -> fwd_a=01; ex_rs2=0 with wb_rd=0 -> fwd_b=00.
REQ-036 rst=1 asserted during MC_BUSY -> outputs 0 that cycle, RUN and stall_cnt=0 next cycle; 70000 forced stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: multi-cycle hold, redirect flush, RAW/load-use stall, forwarding select
//
// Optional feature: define HAZARD_FWD_EN to enable EX operand forwarding
// (only load-use then stalls); undefined, forwarding is off and every RAW
// hazard against EX or MEM stalls.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid, id_rs1, id_rs2      ID-stage instruction and its sources
//   ex_rs1, ex_rs2                EX-stage sources (forwarding compare)
//   ex_rd/mem_rd/wb_rd            destination register per stage
//   ex_reg_w/mem_reg_w/wb_reg_w   stage writes its rd
//   ex_mem2reg                    EX instruction is a load
//   ex_redirect                   taken branch/jump resolved in EX
//   ex_mc_start, mc_done          multi-cycle op in EX / its result ready
//   stall_if/stall_id/stall_ex    hold PC, IF/ID, ID/EX
//   flush_id/bubble_ex/bubble_mem zero IF/ID, ID/EX, EX/MEM
//   fwd_a, fwd_b                  operand source: 00 regfile, 01 MEM, 10 WB
//   stall_cnt                     saturating count of stall_if cycles
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        ex_reg_w,
    input  logic        mem_reg_w,
    input  logic        wb_reg_w,
    input  logic        ex_mem2reg,
    input  logic        ex_redirect,
    input  logic        ex_mc_start,
    input  logic        mc_done,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // x0 is hard-wired zero, so a zero rd never creates a dependency.
    logic ex_hit;
    logic load_use;
    logic raw_stall;
    logic mc_hold;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    assign ex_hit   = id_valid && ex_reg_w && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign load_use = ex_hit && ex_mem2reg;

`ifdef HAZARD_FWD_EN
    // MEM holds the younger value, so it wins over WB.
    assign fwd_a_sel = (mem_reg_w && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) ? 2'b01 :
                       (wb_reg_w  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs1)) ? 2'b10 : 2'b00;
    assign fwd_b_sel = (mem_reg_w && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) ? 2'b01 :
                       (wb_reg_w  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs2)) ? 2'b10 : 2'b00;
    // With bypass paths only a load result is too late for the next op.
    assign raw_stall = load_use;
`else
    logic mem_hit;
    logic unused_fwd_inputs;

    assign mem_hit   = id_valid && mem_reg_w && (mem_rd != 5'd0) &&
                       ((mem_rd == id_rs1) || (mem_rd == id_rs2));
    assign raw_stall = ex_hit || mem_hit;
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    // WB needs no action: the register file writes through to ID reads.
    assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_reg_w, load_use};
`endif

    // A multi-cycle op holds the pipe until the cycle its result is ready.
    assign mc_hold = !mc_done && ((state_q == ST_MC_BUSY) || ex_mc_start);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (ex_mc_start && !mc_done) state_d = ST_MC_BUSY;
            ST_MC_BUSY: if (mc_done)                 state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        flush_id   = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        if (!rst) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            if (mc_hold) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
            end else if (state_q == ST_RUN) begin
                // Redirect squashes the ID instruction, so its hazard is moot.
                if (ex_redirect) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (raw_stall) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
        end
    end

    assign stall_cnt_d = (stall_if && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                 : stall_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with behavioural model
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_reg_w, mem_reg_w, wb_reg_w, ex_mem2reg, ex_redirect, ex_mc_start, mc_done;
    logic        stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_w(ex_reg_w), .mem_reg_w(mem_reg_w), .wb_reg_w(wb_reg_w),
        .ex_mem2reg(ex_mem2reg), .ex_redirect(ex_redirect),
        .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

`ifdef HAZARD_FWD_EN
    localparam bit       RAW_EXP = 1'b0;
    localparam bit [1:0] FWD_MEM = 2'b01;
    localparam bit [1:0] FWD_WB  = 2'b10;
`else
    localparam bit       RAW_EXP = 1'b1;
    localparam bit [1:0] FWD_MEM = 2'b00;
    localparam bit [1:0] FWD_WB  = 2'b00;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decide which single action the cycle takes, then map it to outputs.
    typedef enum int {A_RESET, A_HOLD, A_FLUSH, A_RAW, A_NONE} action_e;

    bit m_busy = 1'b0;
    int m_cnt  = 0;
    bit chk_en = 1'b0;

    function automatic bit id_reads(input logic [4:0] rd);
        return id_valid && (rd != 0) && (rd == id_rs1 || rd == id_rs2);
    endfunction

    function automatic action_e m_action();
        bit raw;
`ifdef HAZARD_FWD_EN
        raw = ex_reg_w && ex_mem2reg && id_reads(ex_rd);
`else
        raw = (ex_reg_w && id_reads(ex_rd)) || (mem_reg_w && id_reads(mem_rd));
`endif
        if (rst)                                 return A_RESET;
        if (!mc_done && (m_busy || ex_mc_start)) return A_HOLD;
        if (m_busy)                              return A_NONE;
        if (ex_redirect)                         return A_FLUSH;
        if (raw)                                 return A_RAW;
        return A_NONE;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        logic [4:0] rds[2];
        bit         ws[2];
        logic [1:0] codes[2];
        rds[0] = mem_rd; ws[0] = mem_reg_w; codes[0] = 2'b01;
        rds[1] = wb_rd;  ws[1] = wb_reg_w;  codes[1] = 2'b10;
`ifdef HAZARD_FWD_EN
        if (!rst)
            for (int k = 0; k < 2; k++)
                if (ws[k] && rds[k] != 0 && rds[k] == rs) return codes[k];
`endif
        return 2'b00;
    endfunction

    function automatic logic [25:0] m_vec();
        logic [5:0] ctl;
        case (m_action())
            A_HOLD:  ctl = 6'b111001;  // {stall_if,stall_id,stall_ex,flush_id,bubble_ex,bubble_mem}
            A_FLUSH: ctl = 6'b000110;
            A_RAW:   ctl = 6'b110010;
            default: ctl = 6'b000000;
        endcase
        return {ctl, m_fwd(ex_rs1), m_fwd(ex_rs2), m_cnt[15:0]};
    endfunction

    always @(posedge clk) begin
        action_e a;
        a = m_action();
        if (a == A_RESET) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if ((a == A_HOLD || a == A_RAW) && m_cnt < 65535) m_cnt <= m_cnt + 1;
            m_busy <= (a == A_HOLD);
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("model", {6'b0, stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem,
                            fwd_a, fwd_b, stall_cnt}, {6'b0, m_vec()});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_reg_w = 0; mem_reg_w = 0; wb_reg_w = 0;
        ex_mem2reg = 0; ex_redirect = 0; ex_mc_start = 0; mc_done = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        ex_mc_start = 1'b1;
        step(); #2;
        check("rst_stall_if", stall_if, 0);
        check("rst_stall_ex", stall_ex, 0);
        check("rst_bubble_mem", bubble_mem, 0);
        check("rst_cnt", stall_cnt, 0);
        chk_en = 1'b1;

        // Load x5 in EX, ID reads x5.
        step(); rst = 0; clear_in();
        id_valid = 1; id_rs1 = 5; ex_mem2reg = 1; ex_reg_w = 1; ex_rd = 5; #2;
        check("lu_stall_if", stall_if, 1);
        check("lu_stall_id", stall_id, 1);
        check("lu_bubble_ex", bubble_ex, 1);
        check("lu_stall_ex", stall_ex, 0);
        check("lu_cnt0", stall_cnt, 0);
        step(); clear_in(); #2;
        check("lu_cnt1", stall_cnt, 1);
        check("lu_one_cycle", stall_if, 0);

        // x0 never stalls.
        step(); clear_in();
        id_valid = 1; ex_rd = 0; ex_reg_w = 1; ex_mem2reg = 1; mem_rd = 0; mem_reg_w = 1; #2;
        check("x0_stall", stall_if, 0);

        // Non-load EX producer, MEM producer, WB producer.
        step(); clear_in();
        id_valid = 1; id_rs2 = 3; ex_rd = 3; ex_reg_w = 1; #2;
        check("raw_ex", stall_if, RAW_EXP);
        step(); clear_in();
        id_valid = 1; id_rs1 = 9; mem_rd = 9; mem_reg_w = 1; #2;
        check("raw_mem", stall_if, RAW_EXP);
        step(); clear_in();
        id_valid = 1; id_rs1 = 9; wb_rd = 9; wb_reg_w = 1; #2;
        check("raw_wb", stall_if, 0);
        step(); clear_in();
        id_valid = 0; id_rs1 = 5; ex_mem2reg = 1; ex_reg_w = 1; ex_rd = 5; #2;
        check("lu_no_valid", stall_if, 0);

        // Redirect beats load-use.
        step(); clear_in();
        id_valid = 1; id_rs1 = 5; ex_mem2reg = 1; ex_reg_w = 1; ex_rd = 5; ex_redirect = 1; #2;
        check("redir_flush", flush_id, 1);
        check("redir_bubble_ex", bubble_ex, 1);
        check("redir_stall_if", stall_if, 0);
        check("redir_stall_id", stall_id, 0);

        // Forwarding select.
        step(); clear_in();
        ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_reg_w = 1; wb_reg_w = 1; #2;
        check("fwd_a_mem", fwd_a, FWD_MEM);
        step(); clear_in();
        ex_rs2 = 0; wb_rd = 0; wb_reg_w = 1; #2;
        check("fwd_b_x0", fwd_b, 0);
        step(); clear_in();
        ex_rs1 = 3; mem_rd = 4; mem_reg_w = 1; wb_rd = 3; wb_reg_w = 1; #2;
        check("fwd_a_wb", fwd_a, FWD_WB);

        // Multi-cycle op finishing after 4 cycles.
        step(); clear_in(); rst = 1;
        step(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            ex_mc_start = 1; mc_done = (i == 4); #2;
            check("mc_stall_if", stall_if, (i < 4));
            check("mc_stall_ex", stall_ex, (i < 4));
            step();
        end
        clear_in(); #2;
        check("mc_run", stall_if, 0);
        check("mc_cnt4", stall_cnt, 4);

        // Redirect ignored while busy, reset mid-busy.
        step(); clear_in(); ex_mc_start = 1; #2;
        check("busy_enter", stall_if, 1);
        step(); ex_mc_start = 0; ex_redirect = 1; #2;
        check("busy_no_flush", flush_id, 0);
        check("busy_hold", stall_if, 1);
        step(); rst = 1; #2;
        check("busy_rst_stall", stall_if, 0);
        check("busy_rst_bmem", bubble_mem, 0);
        step(); rst = 0; clear_in(); #2;
        check("post_rst_run", stall_if, 0);
        check("post_rst_cnt", stall_cnt, 0);

        // Saturation.
        ex_mc_start = 1;
        repeat (70000) step();
        #2;
        check("sat_cnt", stall_cnt, 16'hFFFF);
        check("sat_stall", stall_if, 1);
        step(); #2;
        check("sat_hold", stall_cnt, 16'hFFFF);
        clear_in(); mc_done = 1; #1;
        check("sat_done", stall_if, 0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
